// File: rtl/s_screen_stream.sv
// SSD1306-class SPI OLED driver: power/reset sequence, fixed init table, then frame
// streaming from a byte-wide frame buffer with runtime commands injected between frames.
module s_screen_stream #(
  parameter int CLK_DIV         = 1,
  parameter int STARTUP_WAIT    = 10000000,
  parameter int BYTES_PER_FRAME = 1024,
  parameter int ADDR_W          = 10,
  parameter int READ_LATENCY    = 1,
  parameter int CONTINUOUS      = 1
) (
  input  logic              clk,
  input  logic              rst_btn,
  output logic              ioSclk,
  output logic              ioSdin,
  output logic              ioCs,
  output logic              ioDc,
  output logic              ioReset,
  output logic [ADDR_W-1:0] pixelAddress,
  input  logic [7:0]        pixelData,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_data,
  output logic              cmd_ready,
  input  logic              frame_req,
  output logic              busy,
  output logic              frame_done
);

  localparam int PWR_W = $clog2(4 * STARTUP_WAIT);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PWR_W-1:0]  PWR_LAST   = PWR_W'(4 * STARTUP_WAIT - 1);
  localparam logic [PWR_W-1:0]  PWR_RST_LO = PWR_W'(2 * STARTUP_WAIT);
  localparam logic [PWR_W-1:0]  PWR_RST_HI = PWR_W'(3 * STARTUP_WAIT);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(BYTES_PER_FRAME - 1);
  localparam logic [2:0]        LAT_LAST   = 3'((READ_LATENCY > 1) ? READ_LATENCY - 1 : 0);
  localparam logic [4:0]        INIT_LEN   = 5'd23;
  localparam bit                AUTO_RUN   = (CONTINUOUS != 0);

  typedef enum logic [2:0] {
    POWER, INIT_LOAD, SEND, BYTE_END, IDLE, CMD_LOAD, PIX_FETCH, PIX_LOAD
  } state_t;

  state_t             r_state;
  logic [PWR_W-1:0]   r_pwrCnt;
  logic [DIV_W-1:0]   r_div;
  logic [2:0]         r_bit;
  logic               r_highPhase;
  logic [7:0]         r_shift;
  logic [4:0]         r_initIdx;
  logic [2:0]         r_latCnt;
  logic               r_inFrame;
  logic               r_lastByte;

  logic [PWR_W-1:0]   w_pwrNext;
  logic [7:0]         w_initByte;

  function automatic logic [7:0] initByte(input logic [4:0] idx);
    case (idx)
      5'd0:  initByte = 8'hAE;  5'd1:  initByte = 8'h81;  5'd2:  initByte = 8'h7F;
      5'd3:  initByte = 8'hA6;  5'd4:  initByte = 8'h20;  5'd5:  initByte = 8'h00;
      5'd6:  initByte = 8'hC8;  5'd7:  initByte = 8'h40;  5'd8:  initByte = 8'hA1;
      5'd9:  initByte = 8'hA8;  5'd10: initByte = 8'h3F;  5'd11: initByte = 8'hD3;
      5'd12: initByte = 8'h00;  5'd13: initByte = 8'hD5;  5'd14: initByte = 8'h80;
      5'd15: initByte = 8'hD9;  5'd16: initByte = 8'h22;  5'd17: initByte = 8'hDB;
      5'd18: initByte = 8'h20;  5'd19: initByte = 8'h8D;  5'd20: initByte = 8'h14;
      5'd21: initByte = 8'hA4;  5'd22: initByte = 8'hAF;
      default: initByte = 8'h00;
    endcase
  endfunction

  assign w_pwrNext  = r_pwrCnt + PWR_W'(1);
  assign w_initByte = initByte(r_initIdx);

  // Outputs are registered and updated on the edge that enters each state, so every
  // pin already shows the value belonging to the state during that state's cycles.
  always_ff @(posedge clk) begin
    if (rst_btn) begin
      r_state      <= POWER;
      ioSclk       <= 1'b1;
      ioSdin       <= 1'b0;
      ioCs         <= 1'b1;
      ioDc         <= 1'b1;
      ioReset      <= 1'b1;
      pixelAddress <= '0;
      cmd_ready    <= 1'b0;
      busy         <= 1'b1;
      frame_done   <= 1'b0;
      r_pwrCnt     <= '0;
      r_div        <= '0;
      r_bit        <= '0;
      r_highPhase  <= 1'b0;
      r_shift      <= '0;
      r_initIdx    <= '0;
      r_latCnt     <= '0;
      r_inFrame    <= 1'b0;
      r_lastByte   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (r_state)
        POWER: begin
          if (r_pwrCnt == PWR_LAST) begin
            r_pwrCnt <= '0;
            r_state  <= INIT_LOAD;
            ioDc     <= 1'b0;
            ioCs     <= 1'b0;
          end else begin
            r_pwrCnt <= w_pwrNext;
            ioReset  <= !((w_pwrNext >= PWR_RST_LO) && (w_pwrNext < PWR_RST_HI));
          end
        end

        INIT_LOAD: begin
          r_shift     <= w_initByte;
          ioSdin      <= w_initByte[7];
          ioSclk      <= 1'b0;
          r_bit       <= 3'd7;
          r_div       <= '0;
          r_highPhase <= 1'b0;
          r_initIdx   <= r_initIdx + 5'd1;
          r_state     <= SEND;
        end

        SEND: begin
          if (r_div != DIV_LAST) begin
            r_div <= r_div + DIV_W'(1);
          end else begin
            r_div <= '0;
            if (!r_highPhase) begin
              ioSclk      <= 1'b1;
              r_highPhase <= 1'b1;
            end else if (r_bit == 3'd0) begin
              r_state    <= BYTE_END;
              ioCs       <= 1'b1;
              frame_done <= r_inFrame && r_lastByte;
            end else begin
              r_bit       <= r_bit - 3'd1;
              r_shift     <= {r_shift[6:0], 1'b0};
              ioSdin      <= r_shift[6];
              ioSclk      <= 1'b0;
              r_highPhase <= 1'b0;
            end
          end
        end

        // Chip select drops again straight away unless the stream is going quiet.
        BYTE_END: begin
          if (r_initIdx != INIT_LEN) begin
            r_state <= INIT_LOAD;
            ioDc    <= 1'b0;
            ioCs    <= 1'b0;
          end else if (r_inFrame && !r_lastByte) begin
            r_state  <= PIX_FETCH;
            ioCs     <= 1'b0;
            r_latCnt <= '0;
          end else begin
            r_state   <= IDLE;
            r_inFrame <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end

        IDLE: begin
          if (cmd_valid) begin
            r_shift   <= cmd_data;
            r_state   <= CMD_LOAD;
            ioDc      <= 1'b0;
            ioCs      <= 1'b0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
          end else if (AUTO_RUN || frame_req) begin
            r_state   <= PIX_FETCH;
            r_inFrame <= 1'b1;
            r_latCnt  <= '0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
          end
        end

        CMD_LOAD: begin
          ioSdin      <= r_shift[7];
          ioSclk      <= 1'b0;
          r_bit       <= 3'd7;
          r_div       <= '0;
          r_highPhase <= 1'b0;
          r_state     <= SEND;
        end

        PIX_FETCH: begin
          if (r_latCnt == LAT_LAST) begin
            r_state <= PIX_LOAD;
            ioDc    <= 1'b1;
            ioCs    <= 1'b0;
          end else begin
            r_latCnt <= r_latCnt + 3'd1;
          end
        end

        PIX_LOAD: begin
          r_shift      <= pixelData;
          ioSdin       <= pixelData[7];
          ioSclk       <= 1'b0;
          r_bit        <= 3'd7;
          r_div        <= '0;
          r_highPhase  <= 1'b0;
          r_lastByte   <= (pixelAddress == ADDR_LAST);
          pixelAddress <= (pixelAddress == ADDR_LAST) ? '0 : pixelAddress + ADDR_W'(1);
          r_state      <= SEND;
        end

        default: r_state <= POWER;
      endcase
    end
  end

endmodule
